rc_issue_arb: RTL and testbench



---
 rtl/rc_issue_arb_if.sv | 80 ++++++++
 rtl/rc_issue_arb.sv | 208 ++++++++++++++++++++
 tb/tb_rc_issue_arb.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc_issue_arb_if.sv
// Issue-arbiter bus: four request sources (linefill, writeback, load, store) in front of one issue port.
// master = request sources plus issue consumer; slave = the arbiter.
interface rc_issue_arb_if #(
    parameter int ROB_W  = 6,
    parameter int SET_W  = 8,
    parameter int WAY_W  = 3,
    parameter int OFF_W  = 1,
    parameter int WBUF_W = 4
);
    logic                rf_valid;
    logic                rf_ready;
    logic [2:0]          rf_channel_1hot_id;
    logic [ROB_W-1:0]    rf_rob_id;
    logic [SET_W-1:0]    rf_set;
    logic [WAY_W-1:0]    rf_way;
    logic [OFF_W-1:0]    rf_offset;
    logic                rf_is_store;
    logic [WBUF_W-1:0]   rf_wbuf_id;
    logic [255:0]        rf_refill_data;

    logic                wb_valid;
    logic                wb_ready;
    logic [2:0]          wb_channel_1hot_id;
    logic [ROB_W-1:0]    wb_rob_id;
    logic [SET_W-1:0]    wb_set;
    logic [WAY_W-1:0]    wb_way;
    logic [OFF_W-1:0]    wb_offset;

    logic                ld_valid;
    logic                ld_ready;
    logic [2:0]          ld_channel_1hot_id;
    logic [ROB_W-1:0]    ld_rob_id;
    logic [SET_W-1:0]    ld_set;
    logic [WAY_W-1:0]    ld_way;
    logic [OFF_W-1:0]    ld_offset;

    logic                st_valid;
    logic                st_ready;
    logic [2:0]          st_channel_1hot_id;
    logic [ROB_W-1:0]    st_rob_id;
    logic [SET_W-1:0]    st_set;
    logic [WAY_W-1:0]    st_way;
    logic [OFF_W-1:0]    st_offset;
    logic [WBUF_W-1:0]   st_wbuf_id;

    logic                u_isu_valid;
    logic                u_isu_ready;
    logic [2:0]          u_isu_channel_1hot_id;
    logic [ROB_W-1:0]    u_isu_rob_id;
    logic [2:0]          u_isu_op;
    logic [SET_W-1:0]    u_isu_set;
    logic [WAY_W-1:0]    u_isu_way;
    logic [OFF_W-1:0]    u_isu_offset;
    logic [WBUF_W-1:0]   u_isu_wbuf_id;
    logic [255:0]        u_isu_refill_data;

    modport master (
        output rf_valid, rf_channel_1hot_id, rf_rob_id, rf_set, rf_way, rf_offset,
               rf_is_store, rf_wbuf_id, rf_refill_data,
        output wb_valid, wb_channel_1hot_id, wb_rob_id, wb_set, wb_way, wb_offset,
        output ld_valid, ld_channel_1hot_id, ld_rob_id, ld_set, ld_way, ld_offset,
        output st_valid, st_channel_1hot_id, st_rob_id, st_set, st_way, st_offset, st_wbuf_id,
        output u_isu_ready,
        input  rf_ready, wb_ready, ld_ready, st_ready,
        input  u_isu_valid, u_isu_channel_1hot_id, u_isu_rob_id, u_isu_op, u_isu_set,
               u_isu_way, u_isu_offset, u_isu_wbuf_id, u_isu_refill_data
    );

    modport slave (
        input  rf_valid, rf_channel_1hot_id, rf_rob_id, rf_set, rf_way, rf_offset,
               rf_is_store, rf_wbuf_id, rf_refill_data,
        input  wb_valid, wb_channel_1hot_id, wb_rob_id, wb_set, wb_way, wb_offset,
        input  ld_valid, ld_channel_1hot_id, ld_rob_id, ld_set, ld_way, ld_offset,
        input  st_valid, st_channel_1hot_id, st_rob_id, st_set, st_way, st_offset, st_wbuf_id,
        input  u_isu_ready,
        output rf_ready, wb_ready, ld_ready, st_ready,
        output u_isu_valid, u_isu_channel_1hot_id, u_isu_rob_id, u_isu_op, u_isu_set,
               u_isu_way, u_isu_offset, u_isu_wbuf_id, u_isu_refill_data
    );
endinterface

// File: rtl/rc_issue_arb.sv
// Bank issue arbiter: fixed priority (starved > linefill > writeback > load/store round-robin)
// feeding a one-entry registered issue stage that sustains one request per cycle.
package mpc_types;
    localparam logic [2:0] CACHE_OP_NONE         = 3'd0;
    localparam logic [2:0] CACHE_OP_LOAD         = 3'd1;
    localparam logic [2:0] CACHE_OP_STORE        = 3'd2;
    localparam logic [2:0] CACHE_OP_LOAD_REFILL  = 3'd3;
    localparam logic [2:0] CACHE_OP_STORE_REFILL = 3'd4;
    localparam logic [2:0] CACHE_OP_WB           = 3'd5;
endpackage

module rc_issue_arb #(
    parameter int ROB_W        = 6,
    parameter int SET_W        = 8,
    parameter int WAY_W        = 3,
    parameter int OFF_W        = 1,
    parameter int WBUF_W       = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic           clk,
    input  logic           rst,
    rc_issue_arb_if.slave  bus
);
    import mpc_types::*;

    localparam int         NCNT  = 3;   // starvation-tracked sources: 0 = wb, 1 = ld, 2 = st
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic            ld_en;
    logic            sel_rf, sel_wb, sel_ld, sel_st;
    logic            gnt_rf, gnt_wb, gnt_ld, gnt_st;
    logic [NCNT-1:0] cnt_valid, cnt_grant, starved;
    logic            rr_q, rr_d;

    logic                valid_q, valid_d;
    logic [2:0]          chan_q, chan_d;
    logic [ROB_W-1:0]    rob_q, rob_d;
    logic [2:0]          op_q, op_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [WBUF_W-1:0]   wbuf_q, wbuf_d;
    logic [255:0]        data_q, data_d;

    // The output stage can take a new request when empty or draining this cycle.
    assign ld_en = !valid_q || bus.u_isu_ready;

    assign cnt_valid = {bus.st_valid, bus.ld_valid, bus.wb_valid};
    assign cnt_grant = {gnt_st, gnt_ld, gnt_wb};

    generate
        for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
            logic [3:0] cnt_q, cnt_d;

            assign starved[gi] = cnt_valid[gi] && (cnt_q == LIMIT);

            always_comb begin
                cnt_d = cnt_q;
                if (!cnt_valid[gi] || cnt_grant[gi]) begin
                    cnt_d = 4'd0;
                end else if (cnt_q != LIMIT) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= 4'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        sel_rf = 1'b0;
        sel_wb = 1'b0;
        sel_ld = 1'b0;
        sel_st = 1'b0;
        if (starved[0]) begin
            sel_wb = 1'b1;
        end else if (starved[1]) begin
            sel_ld = 1'b1;
        end else if (starved[2]) begin
            sel_st = 1'b1;
        end else if (bus.rf_valid) begin
            sel_rf = 1'b1;
        end else if (bus.wb_valid) begin
            sel_wb = 1'b1;
        end else if (bus.ld_valid && bus.st_valid) begin
            sel_ld = !rr_q;
            sel_st = rr_q;
        end else if (bus.ld_valid) begin
            sel_ld = 1'b1;
        end else if (bus.st_valid) begin
            sel_st = 1'b1;
        end
    end

    assign gnt_rf = ld_en && !rst && sel_rf;
    assign gnt_wb = ld_en && !rst && sel_wb;
    assign gnt_ld = ld_en && !rst && sel_ld;
    assign gnt_st = ld_en && !rst && sel_st;

    assign bus.rf_ready = gnt_rf;
    assign bus.wb_ready = gnt_wb;
    assign bus.ld_ready = gnt_ld;
    assign bus.st_ready = gnt_st;

    always_comb begin
        rr_d = rr_q;
        if (gnt_ld) begin
            rr_d = 1'b1;
        end else if (gnt_st) begin
            rr_d = 1'b0;
        end
    end

    // Unused issued fields are forced to zero so downstream never sees stale source data.
    always_comb begin
        valid_d = valid_q;
        chan_d  = chan_q;
        rob_d   = rob_q;
        op_d    = op_q;
        set_d   = set_q;
        way_d   = way_q;
        off_d   = off_q;
        wbuf_d  = wbuf_q;
        data_d  = data_q;
        if (ld_en) begin
            valid_d = gnt_rf || gnt_wb || gnt_ld || gnt_st;
            if (gnt_rf) begin
                chan_d = bus.rf_channel_1hot_id;
                rob_d  = bus.rf_rob_id;
                op_d   = bus.rf_is_store ? CACHE_OP_STORE_REFILL : CACHE_OP_LOAD_REFILL;
                set_d  = bus.rf_set;
                way_d  = bus.rf_way;
                off_d  = bus.rf_offset;
                wbuf_d = bus.rf_is_store ? bus.rf_wbuf_id : '0;
                data_d = bus.rf_refill_data;
            end else if (gnt_wb) begin
                chan_d = bus.wb_channel_1hot_id;
                rob_d  = bus.wb_rob_id;
                op_d   = CACHE_OP_WB;
                set_d  = bus.wb_set;
                way_d  = bus.wb_way;
                off_d  = bus.wb_offset;
                wbuf_d = '0;
                data_d = '0;
            end else if (gnt_ld) begin
                chan_d = bus.ld_channel_1hot_id;
                rob_d  = bus.ld_rob_id;
                op_d   = CACHE_OP_LOAD;
                set_d  = bus.ld_set;
                way_d  = bus.ld_way;
                off_d  = bus.ld_offset;
                wbuf_d = '0;
                data_d = '0;
            end else if (gnt_st) begin
                chan_d = bus.st_channel_1hot_id;
                rob_d  = bus.st_rob_id;
                op_d   = CACHE_OP_STORE;
                set_d  = bus.st_set;
                way_d  = bus.st_way;
                off_d  = bus.st_offset;
                wbuf_d = bus.st_wbuf_id;
                data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= 1'b0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            rob_q   <= '0;
            op_q    <= '0;
            set_q   <= '0;
            way_q   <= '0;
            off_q   <= '0;
            wbuf_q  <= '0;
            data_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
            rob_q   <= rob_d;
            op_q    <= op_d;
            set_q   <= set_d;
            way_q   <= way_d;
            off_q   <= off_d;
            wbuf_q  <= wbuf_d;
            data_q  <= data_d;
        end
    end

    assign bus.u_isu_valid           = valid_q;
    assign bus.u_isu_channel_1hot_id = chan_q;
    assign bus.u_isu_rob_id          = rob_q;
    assign bus.u_isu_op              = op_q;
    assign bus.u_isu_set             = set_q;
    assign bus.u_isu_way             = way_q;
    assign bus.u_isu_offset          = off_q;
    assign bus.u_isu_wbuf_id         = wbuf_q;
    assign bus.u_isu_refill_data     = data_q;
endmodule

// File: tb/tb_rc_issue_arb.sv
// Scoreboard bench for rc_issue_arb: expected issues are queued as stimulus is set up
// and popped as the issue port fires; grant order is checked cycle by cycle.
module tb_rc_issue_arb;
    import mpc_types::*;

    localparam int ROB_W  = 6;
    localparam int SET_W  = 8;
    localparam int WAY_W  = 3;
    localparam int OFF_W  = 1;
    localparam int WBUF_W = 4;
    localparam int RF = 0;
    localparam int WB = 1;
    localparam int LD = 2;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rc_issue_arb_if #(.ROB_W(ROB_W), .SET_W(SET_W), .WAY_W(WAY_W), .OFF_W(OFF_W), .WBUF_W(WBUF_W)) bus ();

    rc_issue_arb #(
        .ROB_W(ROB_W), .SET_W(SET_W), .WAY_W(WAY_W), .OFF_W(OFF_W), .WBUF_W(WBUF_W),
        .STARVE_LIMIT(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]        op;
        logic [2:0]        chan;
        logic [ROB_W-1:0]  rob;
        logic [SET_W-1:0]  set;
        logic [WAY_W-1:0]  way;
        logic [OFF_W-1:0]  off;
        logic [WBUF_W-1:0] wbuf;
        logic [255:0]      data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   seq[4];
    int   left[4];
    bit   rf_store;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-source request fields derived from (source, request sequence number).
    function automatic logic [2:0] f_chan(int s, int k);
        return 3'(1 << ((s + k) % 3));
    endfunction
    function automatic logic [ROB_W-1:0] f_rob(int s, int k);
        return ROB_W'((s * 16 + k) % 64);
    endfunction
    function automatic logic [SET_W-1:0] f_set(int s, int k);
        return SET_W'((s * 37 + k * 11 + 1) % 256);
    endfunction
    function automatic logic [WAY_W-1:0] f_way(int s, int k);
        return WAY_W'((s + k * 3) % 8);
    endfunction
    function automatic logic [OFF_W-1:0] f_off(int s, int k);
        return OFF_W'((s + k) % 2);
    endfunction
    function automatic logic [WBUF_W-1:0] f_wbuf(int s, int k);
        return WBUF_W'((s + k + 5) % 16);
    endfunction
    function automatic logic [255:0] f_data(int k);
        logic [7:0] b;
        b = ((k % 2) == 1) ? 8'hA5 : 8'h3C;
        return {32{b}};
    endfunction
    function automatic logic [3:0] oh(int s);
        return 4'(1 << s);
    endfunction

    function automatic exp_t mk_exp(int s, int k, bit is_store);
        exp_t e;
        e.chan = f_chan(s, k);
        e.rob  = f_rob(s, k);
        e.set  = f_set(s, k);
        e.way  = f_way(s, k);
        e.off  = f_off(s, k);
        e.wbuf = '0;
        e.data = '0;
        case (s)
            RF: begin
                e.op   = is_store ? CACHE_OP_STORE_REFILL : CACHE_OP_LOAD_REFILL;
                e.wbuf = is_store ? f_wbuf(s, k) : '0;
                e.data = f_data(k);
            end
            WB:      e.op = CACHE_OP_WB;
            LD:      e.op = CACHE_OP_LOAD;
            default: begin
                e.op   = CACHE_OP_STORE;
                e.wbuf = f_wbuf(s, k);
            end
        endcase
        return e;
    endfunction

    task automatic push(input int s, input int k);
        exp_q.push_back(mk_exp(s, k, rf_store));
    endtask

    task automatic apply();
        bus.rf_valid           = left[RF] > 0;
        bus.rf_channel_1hot_id = f_chan(RF, seq[RF]);
        bus.rf_rob_id          = f_rob(RF, seq[RF]);
        bus.rf_set             = f_set(RF, seq[RF]);
        bus.rf_way             = f_way(RF, seq[RF]);
        bus.rf_offset          = f_off(RF, seq[RF]);
        bus.rf_is_store        = rf_store;
        bus.rf_wbuf_id         = f_wbuf(RF, seq[RF]);
        bus.rf_refill_data     = f_data(seq[RF]);
        bus.wb_valid           = left[WB] > 0;
        bus.wb_channel_1hot_id = f_chan(WB, seq[WB]);
        bus.wb_rob_id          = f_rob(WB, seq[WB]);
        bus.wb_set             = f_set(WB, seq[WB]);
        bus.wb_way             = f_way(WB, seq[WB]);
        bus.wb_offset          = f_off(WB, seq[WB]);
        bus.ld_valid           = left[LD] > 0;
        bus.ld_channel_1hot_id = f_chan(LD, seq[LD]);
        bus.ld_rob_id          = f_rob(LD, seq[LD]);
        bus.ld_set             = f_set(LD, seq[LD]);
        bus.ld_way             = f_way(LD, seq[LD]);
        bus.ld_offset          = f_off(LD, seq[LD]);
        bus.st_valid           = left[ST] > 0;
        bus.st_channel_1hot_id = f_chan(ST, seq[ST]);
        bus.st_rob_id          = f_rob(ST, seq[ST]);
        bus.st_set             = f_set(ST, seq[ST]);
        bus.st_way             = f_way(ST, seq[ST]);
        bus.st_offset          = f_off(ST, seq[ST]);
        bus.st_wbuf_id         = f_wbuf(ST, seq[ST]);
    endtask

    // One clock: sample readies/valid mid-cycle, then advance granted sources after the edge.
    task automatic cycle(output logic [3:0] r, output logic v);
        @(negedge clk);
        r = {bus.st_ready, bus.ld_ready, bus.wb_ready, bus.rf_ready};
        v = bus.u_isu_valid;
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            if (r[s]) begin
                seq[s]++;
                left[s]--;
            end
        end
        apply();
    endtask

    always @(negedge clk) begin
        if (!rst && bus.u_isu_valid && bus.u_isu_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 256'(bus.u_isu_rob_id), 256'(0));
                check("unexpected_issue_valid", 256'(1), 256'(0));
            end else begin
                mon_e = exp_q.pop_front();
                $display("issue op=%0d chan=%0h rob=%0h set=%0h way=%0h off=%0h wbuf=%0h",
                         bus.u_isu_op, bus.u_isu_channel_1hot_id, bus.u_isu_rob_id, bus.u_isu_set,
                         bus.u_isu_way, bus.u_isu_offset, bus.u_isu_wbuf_id);
                check("issue_op",   256'(bus.u_isu_op),              256'(mon_e.op));
                check("issue_chan", 256'(bus.u_isu_channel_1hot_id), 256'(mon_e.chan));
                check("issue_rob",  256'(bus.u_isu_rob_id),          256'(mon_e.rob));
                check("issue_set",  256'(bus.u_isu_set),             256'(mon_e.set));
                check("issue_way",  256'(bus.u_isu_way),             256'(mon_e.way));
                check("issue_off",  256'(bus.u_isu_offset),          256'(mon_e.off));
                check("issue_wbuf", 256'(bus.u_isu_wbuf_id),         256'(mon_e.wbuf));
                check("issue_data", bus.u_isu_refill_data,           mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r;
        logic       v;
        int         pat[10];
        int         k[4];

        for (int s = 0; s < 4; s++) begin
            seq[s]  = 0;
            left[s] = 1;
        end
        rf_store        = 1'b0;
        bus.u_isu_ready = 1'b1;
        rst             = 1'b1;
        apply();
        @(posedge clk);
        #1;

        // Reset with every source requesting.
        for (int i = 0; i < 3; i++) begin
            cycle(r, v);
            check("rst_ready", 256'(r), 256'(0));
            check("rst_valid", 256'(v), 256'(0));
        end
        check("rst_op",   256'(bus.u_isu_op),          256'(0));
        check("rst_rob",  256'(bus.u_isu_rob_id),      256'(0));
        check("rst_data", bus.u_isu_refill_data,       256'(0));
        check("rst_wbuf", 256'(bus.u_isu_wbuf_id),     256'(0));
        push(RF, 0); push(WB, 0); push(LD, 0); push(ST, 0);
        rst = 1'b0;
        cycle(r, v); check("first_grant_rf", 256'(r), 256'(oh(RF))); check("first_valid", 256'(v), 256'(0));
        cycle(r, v); check("grant_wb",       256'(r), 256'(oh(WB))); check("valid_after_rf", 256'(v), 256'(1));
        cycle(r, v); check("grant_ld",       256'(r), 256'(oh(LD)));
        cycle(r, v); check("grant_st",       256'(r), 256'(oh(ST)));
        cycle(r, v); check("idle_ready",     256'(r), 256'(0)); check("last_valid", 256'(v), 256'(1));
        cycle(r, v); check("idle_valid",     256'(v), 256'(0));

        // Round-robin load/store.
        left[LD] = 6;
        left[ST] = 6;
        apply();
        for (int i = 0; i < 6; i++) begin
            push(LD, seq[LD] + i);
            push(ST, seq[ST] + i);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(r, v);
            check("rr_grant", 256'(r), 256'(oh((i % 2 == 0) ? LD : ST)));
        end
        cycle(r, v);
        cycle(r, v);
        check("rr_drained", 256'(v), 256'(0));

        // Priority with a store-refill.
        rf_store = 1'b1;
        left[RF] = 1;
        left[WB] = 1;
        left[LD] = 1;
        apply();
        push(RF, seq[RF]); push(WB, seq[WB]); push(LD, seq[LD]);
        cycle(r, v); check("prio_rf", 256'(r), 256'(oh(RF)));
        cycle(r, v); check("prio_wb", 256'(r), 256'(oh(WB)));
        cycle(r, v); check("prio_ld", 256'(r), 256'(oh(LD)));
        cycle(r, v);
        cycle(r, v);
        rf_store = 1'b0;
        apply();

        // Starvation escape for wb against a continuous linefill stream.
        pat = '{RF, RF, RF, WB, RF, RF, RF, WB, RF, RF};
        left[RF] = 8;
        left[WB] = 2;
        apply();
        for (int s = 0; s < 4; s++) k[s] = seq[s];
        for (int i = 0; i < 10; i++) begin
            push(pat[i], k[pat[i]]);
            k[pat[i]]++;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(r, v);
            check("starve_grant", 256'(r), 256'(oh(pat[i])));
            if (i == 3) check("wb_cnt_after_grant", 256'(dut.g_cnt[0].cnt_q), 256'(0));
        end
        cycle(r, v);
        cycle(r, v);

        // Backpressure with a load waiting behind a held writeback.
        bus.u_isu_ready = 1'b0;
        left[WB] = 1;
        left[LD] = 1;
        apply();
        push(WB, seq[WB]); push(LD, seq[LD]);
        cycle(r, v); check("bp_first_grant", 256'(r), 256'(oh(WB)));
        for (int i = 0; i < 5; i++) begin
            cycle(r, v);
            check("bp_ready",   256'(r), 256'(0));
            check("bp_valid",   256'(v), 256'(1));
            check("bp_op_hold", 256'(bus.u_isu_op), 256'(CACHE_OP_WB));
            check("bp_rob_hold", 256'(bus.u_isu_rob_id), 256'(f_rob(WB, seq[WB] - 1)));
        end
        bus.u_isu_ready = 1'b1;
        cycle(r, v); check("bp_release_grant", 256'(r), 256'(oh(LD)));
        cycle(r, v); check("bp_ld_valid", 256'(v), 256'(1)); check("bp_after_ready", 256'(r), 256'(0));
        cycle(r, v); check("bp_idle", 256'(v), 256'(0));

        // Reset pulse while a store is stalled in the output stage.
        bus.u_isu_ready = 1'b0;
        left[ST] = 1;
        apply();
        cycle(r, v); check("ms_grant_st", 256'(r), 256'(oh(ST)));
        cycle(r, v); check("ms_stalled", 256'(v), 256'(1));
        rst = 1'b1;
        cycle(r, v);
        rst = 1'b0;
        bus.u_isu_ready = 1'b1;
        cycle(r, v); check("ms_valid_dropped", 256'(v), 256'(0)); check("ms_ready", 256'(r), 256'(0));
        cycle(r, v); check("ms_valid_stays", 256'(v), 256'(0));

        check("queue_empty", 256'(exp_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
